reg_bank: RTL
=============

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 16, data width of each register in bits.
REQ-002 SHALL have parameter REG_ADDR_BITS, default 4, address width; depth = 2**REG_ADDR_BITS.
REQ-003 SHALL have parameter READ_PORTS, default 2, number of independent read ports (1..4).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wrEn  input  1  write request.
REQ-007 SHALL have port wrAddr  input  REG_ADDR_BITS  write address.
REQ-008 SHALL have port wrData  input  REG_WIDTH  write data.
REQ-009 SHALL have port rdAddr  input  READ_PORTS*REG_ADDR_BITS  packed read addresses; port k in bits [k*REG_ADDR_BITS +: REG_ADDR_BITS].
REQ-010 SHALL have port rdData  output  READ_PORTS*REG_WIDTH  packed registered read data; port k in bits [k*REG_WIDTH +: REG_WIDTH].
REQ-011 SHALL have port clrReq  input  1  request a full sequential clear.
REQ-012 SHALL have port busy  output  1  high while the clear sequence runs.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-014 SHALL, in CLEAR, write zero to register clrPtr each cycle and increment clrPtr by 1.
REQ-015 SHALL, in CLEAR with clrPtr = 2**REG_ADDR_BITS-1, write that register and go to IDLE next cycle; clrPtr wraps to 0.
REQ-016 SHALL, in IDLE with clrReq=1, go to CLEAR with clrPtr=0; clrReq while in CLEAR is ignored (no restart).
REQ-017 SHALL drive busy=1 exactly while state is CLEAR; a clear takes 2**REG_ADDR_BITS cycles.
REQ-018 SHALL, in IDLE with wrEn=1, write wrData to wrAddr at the clock edge; wrEn while busy=1 is discarded.
REQ-019 SHALL register each read port with 1-cycle latency: rdData[k] after edge t = contents of rdAddr[k] sampled at edge t.
REQ-020 SHALL bypass: if wrEn=1, not busy, and wrAddr equals rdAddr[k] in the same cycle, rdData[k] after that edge = wrData.
REQ-021 SHALL, while busy=1, load 0 into every rdData port.
REQ-022 SHALL allow all read ports to address the same register simultaneously, each returning identical data.
REQ-023 SHALL give clrReq and wrEn arriving in the same IDLE cycle: write performed, CLEAR entered, write later overwritten by clear.

Reset
REQ-024 SHALL, on rst_n=0, immediately and asynchronously set rdData=0, clrPtr=0, state=CLEAR, busy=1.
REQ-025 SHALL not reset register-array contents directly; the CLEAR sequence after rst_n rises zeroes them.
REQ-026 SHALL, on reset asserted mid-clear or mid-write, abandon the operation and restart the full clear from address 0 after release.

Configuration
REQ-027 SHALL support macro REG_BANK_ZERO_REG_EN.
REQ-028 SHALL, with REG_BANK_ZERO_REG_EN defined, hardwire register 0 to zero: writes to address 0 discarded, bypass to address 0 suppressed, reads of address 0 return 0.
REQ-029 SHALL, with REG_BANK_ZERO_REG_EN undefined, treat register 0 as an ordinary writable register.

Verification
REQ-030 SHALL cover reset: pulse rst_n low mid-operation -> rdData=0, busy=1 at once; busy stays high 16 cycles after release (defaults), then 0; every register reads 0.
REQ-031 SHALL cover write/read: write 0xBEEF to reg 5, next cycle read port 0 addr 5 -> rdData[0]=0xBEEF one cycle later.
REQ-032 SHALL cover bypass: wrEn=1 wrAddr=3 wrData=0x1234, rdAddr[1]=3 same cycle -> rdData[1]=0x1234 after that edge.
REQ-033 SHALL cover clear: fill regs with 0xA5A5, pulse clrReq -> busy 16 cycles, writes during busy ignored, rdData=0 during busy, all regs read 0 after.
REQ-034 SHALL cover zero register: with REG_BANK_ZERO_REG_EN, write 0xFFFF to reg 0 -> reads 0; without macro -> reads 0xFFFF.
REQ-035 SHALL cover parameters: REG_WIDTH=32, REG_ADDR_BITS=3, READ_PORTS=3, three ports reading regs 1,2,7 -> correct values; clear lasts 8 cycles.

Source files
------------

// File: rtl/reg_bank.sv
// Multi-port register bank with a one-cycle registered read, write-to-read bypass and a sequential clear FSM.
// Define REG_BANK_ZERO_REG_EN to make register 0 a constant zero.
module reg_bank #(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 4,
    parameter int READ_PORTS    = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wrEn,
    input  logic [REG_ADDR_BITS-1:0]           wrAddr,
    input  logic [REG_WIDTH-1:0]               wrData,
    input  logic [READ_PORTS*REG_ADDR_BITS-1:0] rdAddr,
    output logic [READ_PORTS*REG_WIDTH-1:0]    rdData,
    input  logic                               clrReq,
    output logic                               busy
);

    localparam int DEPTH = 2 ** REG_ADDR_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [REG_ADDR_BITS-1:0]   r_clr_ptr;
    logic [REG_ADDR_BITS-1:0]   w_clr_ptr_next;
    logic [REG_WIDTH-1:0]       r_mem [DEPTH];
    logic                       w_busy;
    logic                       w_wr_fire;

    assign w_busy = (r_state == CLEAR);
    assign busy   = w_busy;

`ifdef REG_BANK_ZERO_REG_EN
    assign w_wr_fire = wrEn && !w_busy && (wrAddr != '0);
`else
    assign w_wr_fire = wrEn && !w_busy;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        case (r_state)
            IDLE: begin
                if (clrReq) begin
                    w_state_next   = CLEAR;
                    w_clr_ptr_next = '0;
                end
            end
            CLEAR: begin
                w_clr_ptr_next = r_clr_ptr + REG_ADDR_BITS'(1);
                if (r_clr_ptr == '1) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: the array has no reset term; the CLEAR pass that follows every reset zeroes it.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_fire) begin
            r_mem[wrAddr] <= wrData;
        end
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        logic [REG_ADDR_BITS-1:0] w_rd_addr;
        logic [REG_WIDTH-1:0]     w_rd_next;
        logic [REG_WIDTH-1:0]     r_rd_q;

        assign w_rd_addr = rdAddr[g*REG_ADDR_BITS +: REG_ADDR_BITS];

        // Priority: clear forces zero, then the hardwired zero register, then bypass, then storage.
        always_comb begin
            w_rd_next = r_mem[w_rd_addr];
            if (w_wr_fire && (wrAddr == w_rd_addr)) begin
                w_rd_next = wrData;
            end
`ifdef REG_BANK_ZERO_REG_EN
            if (w_rd_addr == '0) begin
                w_rd_next = '0;
            end
`endif
            if (w_busy) begin
                w_rd_next = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_q <= '0;
            end else begin
                r_rd_q <= w_rd_next;
            end
        end

        assign rdData[g*REG_WIDTH +: REG_WIDTH] = r_rd_q;
    end

endmodule
